// File: rtl/ahb_slave_interface.sv
// ahb_slave_interface
// AHB-side front end of the AHB-to-APB bridge. It qualifies AHB transfers
// into a single-cycle valid and decodes a one-hot select over three 64 MB
// slots starting at BASE_ADDR. It also provides free-running 1- and 2-cycle
// delayed copies of address, write data and direction, and keeps saturating
// read/write transfer counters.
// Optional feature macro: AHB_SLV_ERR_RESP_EN. When it is defined, a
// two-cycle AHB ERROR response is generated for active transfers to
// unmapped addresses. When it is undefined, hresp is tied to OKAY,
// err_hready is tied to 1, and unmapped accesses are ignored.
module ahb_slave_interface #(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             hwrite,
   input  logic             hreadyin,
   input  logic [1:0]       htrans,
   input  logic [31:0]      haddr,
   input  logic [31:0]      hwdata,
   output logic             valid,
   output logic [2:0]       tempselx,
   output logic [31:0]      haddr1,
   output logic [31:0]      haddr2,
   output logic [31:0]      hwdata1,
   output logic [31:0]      hwdata2,
   output logic             hwritereg,
   output logic             hwritereg1,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic [1:0]       hresp,
   output logic             err_hready
);

   // Size of the mapped window: three consecutive 64 MB slots.
   localparam logic [31:0] WINDOW_LAST = 32'h0BFF_FFFF;

   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   logic [31:0]      haddr1_q, haddr2_q;
   logic [31:0]      hwdata1_q, hwdata2_q;
   logic             hwrite1_q, hwrite2_q;
   logic [CNT_W-1:0] wr_count_q, wr_count_d;
   logic [CNT_W-1:0] rd_count_q, rd_count_d;

   logic [31:0]      addr_offset;
   logic             in_range;
   logic             active;
   logic             err_idle;
   logic [2:0]       sel;

   // Offset into the window. The lower-bound compare keeps addresses
   // below BASE_ADDR from wrapping into the window.
   assign addr_offset = haddr - BASE_ADDR;
   assign in_range    = (haddr >= BASE_ADDR) && (addr_offset <= WINDOW_LAST);

   // Only NONSEQ and SEQ transfers with HREADY high carry a real access.
   assign active = hreadyin && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   // Slot decode from offset bits [27:26]. This decode is not gated by htrans.
   always_comb begin
      sel = 3'b000;
      if (in_range) begin
         case (addr_offset[27:26])
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
         endcase
      end
   end

   assign tempselx = sel;
   assign valid    = active && in_range && !hreset && err_idle;

`ifdef AHB_SLV_ERR_RESP_EN
   typedef enum logic [1:0] {
      ERR_IDLE = 2'd0,
      ERR_1    = 2'd1,
      ERR_2    = 2'd2
   } err_state_t;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   err_state_t err_state_q, err_state_d;
   logic [1:0] hresp_d;
   logic       err_hready_d;

   // Error FSM state register.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         err_state_q <= ERR_IDLE;
      end else begin
         err_state_q <= err_state_d;
      end
   end

   // Error FSM next state and response outputs. Unmapped accesses seen in
   // ERR_1 or ERR_2 do not restart the sequence. Outputs read OKAY/ready
   // while reset is held, even before the state register has been cleared.
   always_comb begin
      err_state_d  = err_state_q;
      hresp_d      = HRESP_OKAY;
      err_hready_d = 1'b1;
      case (err_state_q)
         ERR_IDLE: begin
            if (active && !in_range) begin
               err_state_d = ERR_1;
            end
         end
         ERR_1: begin
            hresp_d      = HRESP_ERROR;
            err_hready_d = 1'b0;
            err_state_d  = ERR_2;
         end
         ERR_2: begin
            hresp_d      = HRESP_ERROR;
            err_hready_d = 1'b1;
            err_state_d  = ERR_IDLE;
         end
         default: begin
            err_state_d = ERR_IDLE;
         end
      endcase
      if (hreset) begin
         hresp_d      = HRESP_OKAY;
         err_hready_d = 1'b1;
      end
   end

   assign err_idle   = (err_state_q == ERR_IDLE);
   assign hresp      = hresp_d;
   assign err_hready = err_hready_d;
`else
   // No error FSM: always OKAY, never stall, and unmapped accesses just
   // fail to raise valid.
   assign err_idle   = 1'b1;
   assign hresp      = 2'b00;
   assign err_hready = 1'b1;
`endif

   // Free-running two-stage pipeline of address, write data and direction.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         haddr1_q  <= '0;
         haddr2_q  <= '0;
         hwdata1_q <= '0;
         hwdata2_q <= '0;
         hwrite1_q <= 1'b0;
         hwrite2_q <= 1'b0;
      end else begin
         haddr1_q  <= haddr;
         haddr2_q  <= haddr1_q;
         hwdata1_q <= hwdata;
         hwdata2_q <= hwdata1_q;
         hwrite1_q <= hwrite;
         hwrite2_q <= hwrite1_q;
      end
   end

   // Counter next state: bump one counter per valid transfer, and hold at all-ones.
   always_comb begin
      wr_count_d = wr_count_q;
      rd_count_d = rd_count_q;
      if (valid) begin
         if (hwrite) begin
            if (wr_count_q != {CNT_W{1'b1}}) begin
               wr_count_d = wr_count_q + 1'b1;
            end
         end else begin
            if (rd_count_q != {CNT_W{1'b1}}) begin
               rd_count_d = rd_count_q + 1'b1;
            end
         end
      end
   end

   // Counter registers.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign haddr1     = haddr1_q;
   assign haddr2     = haddr2_q;
   assign hwdata1    = hwdata1_q;
   assign hwdata2    = hwdata2_q;
   assign hwritereg  = hwrite1_q;
   assign hwritereg1 = hwrite2_q;
   assign wr_count   = wr_count_q;
   assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb_ahb_slave_interface
// Bench for ahb_slave_interface, built with CNT_W = 4. It applies directed
// sequences, a vector table and random traffic. A cycle-level behavioural
// model (address arithmetic, history registers, saturating integer counts
// and an error countdown) predicts every output. The error expectations
// follow AHB_SLV_ERR_RESP_EN.
module tb_ahb_slave_interface;

   localparam int          TB_CNT_W = 4;
   localparam logic [31:0] BASE     = 32'h8000_0000;
   localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic                hclk;
   logic                hreset;
   logic                hwrite;
   logic                hreadyin;
   logic [1:0]          htrans;
   logic [31:0]         haddr;
   logic [31:0]         hwdata;
   logic                valid;
   logic [2:0]          tempselx;
   logic [31:0]         haddr1, haddr2, hwdata1, hwdata2;
   logic                hwritereg, hwritereg1;
   logic [TB_CNT_W-1:0] wr_count, rd_count;
   logic [1:0]          hresp;
   logic                err_hready;

   ahb_slave_interface #(.CNT_W(TB_CNT_W), .BASE_ADDR(BASE)) dut (
      .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
      .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .valid(valid),
      .tempselx(tempselx), .haddr1(haddr1), .haddr2(haddr2),
      .hwdata1(hwdata1), .hwdata2(hwdata2), .hwritereg(hwritereg),
      .hwritereg1(hwritereg1), .wr_count(wr_count), .rd_count(rd_count),
      .hresp(hresp), .err_hready(err_hready)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model state, holding the values after the most recent edge.
   bit          model_ok = 0;
   logic [31:0] m_a1, m_a2, m_d1, m_d2;
   logic        m_w1, m_w2;
   int          m_wr, m_rd;
   int          m_err_left;   // 2: first error cycle, 1: second, 0: none

   // Combinational outputs captured mid-cycle by the last step.
   logic        cap_valid;
   logic [2:0]  cap_sel;
   logic [1:0]  cap_hresp;
   logic        cap_hready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic m_in_range(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'h0C00_0000);
   endfunction

   function automatic logic [2:0] m_sel(input logic [31:0] a);
      int slot;
      if (!m_in_range(a)) return 3'b000;
      slot = int'((a - BASE) / 32'h0400_0000);
      return 3'(1 << slot);
   endfunction

   // One bus cycle: drive inputs, check every output against the model,
   // take the clock edge, then advance the model.
   task automatic step(input logic rst, input logic wr, input logic rdy,
                       input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d);
      logic       e_in, e_act, e_valid, e_rdy;
      logic [2:0] e_sel;
      logic [1:0] e_resp;
      hreset = rst; hwrite = wr; hreadyin = rdy; htrans = tr; haddr = a; hwdata = d;
      #2;
      e_in    = m_in_range(a);
      e_sel   = m_sel(a);
      e_act   = rdy && tr[1];
      e_valid = e_act && e_in && !rst && (m_err_left == 0);
`ifdef AHB_SLV_ERR_RESP_EN
      e_resp  = (!rst && m_err_left != 0) ? 2'b01 : 2'b00;
      e_rdy   = !(!rst && m_err_left == 2);
`else
      e_resp  = 2'b00;
      e_rdy   = 1'b1;
`endif
      chk("valid", 32'(valid), 32'(e_valid));
      chk("tempselx", 32'(tempselx), 32'(e_sel));
      if (model_ok) begin
         chk("hresp", 32'(hresp), 32'(e_resp));
         chk("err_hready", 32'(err_hready), 32'(e_rdy));
         chk("haddr1", haddr1, m_a1);
         chk("haddr2", haddr2, m_a2);
         chk("hwdata1", hwdata1, m_d1);
         chk("hwdata2", hwdata2, m_d2);
         chk("hwritereg", 32'(hwritereg), 32'(m_w1));
         chk("hwritereg1", 32'(hwritereg1), 32'(m_w2));
         chk("wr_count", 32'(wr_count), 32'(m_wr));
         chk("rd_count", 32'(rd_count), 32'(m_rd));
      end
      cap_valid = valid; cap_sel = tempselx; cap_hresp = hresp; cap_hready = err_hready;
      $display("cyc %0d rst=%0b wr=%0b rdy=%0b tr=%0d addr=%h data=%h valid=%0b sel=%b resp=%0d rdy_o=%0b wr_cnt=%0d rd_cnt=%0d",
               cyc, rst, wr, rdy, tr, a, d, valid, tempselx, hresp, err_hready, wr_count, rd_count);
      @(posedge hclk);
      if (rst) begin
         m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w1 = 0; m_w2 = 0;
         m_wr = 0; m_rd = 0; m_err_left = 0;
         model_ok = 1;
      end else begin
         m_a2 = m_a1; m_a1 = a;
         m_d2 = m_d1; m_d1 = d;
         m_w2 = m_w1; m_w1 = wr;
         if (e_valid) begin
            if (wr) begin
               if (m_wr < CNT_MAX) m_wr++;
            end else begin
               if (m_rd < CNT_MAX) m_rd++;
            end
         end
`ifdef AHB_SLV_ERR_RESP_EN
         if (m_err_left > 0) m_err_left--;
         else if (e_act && !e_in) m_err_left = 2;
`endif
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
   endtask

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rdy;
      logic [1:0]  tr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        exp_valid;
      logic [2:0]  exp_sel;
   } vec_t;

   vec_t vecs[16];

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return BASE + $urandom_range(0, 32'h0BFF_FFFF);
         1:       return BASE + 32'h0BFF_FFFC + $urandom_range(0, 7);
         2:       return BASE - $urandom_range(1, 4);
         3:       return $urandom;
         4:       return BASE + 32'h0400_0000 * $urandom_range(0, 2) + $urandom_range(0, 15);
         default: return BASE + 32'h0C00_0000 + $urandom_range(0, 16);
      endcase
   endfunction

   initial begin
      hreset = 1'b1; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00;
      haddr = '0; hwdata = '0;
      m_err_left = 0;
      @(posedge hclk);
      #1;

      // Reset held for two cycles with a live NONSEQ transfer.
      step(1'b1, 1'b0, 1'b1, 2'b10, 32'h8000_0010, 32'h0);
      chk("rst_valid0", 32'(cap_valid), 32'd0);
      step(1'b1, 1'b0, 1'b1, 2'b10, 32'h8000_0010, 32'h0);
      chk("rst_valid1", 32'(cap_valid), 32'd0);
      chk("rst_haddr1", haddr1, 32'h0);
      chk("rst_haddr2", haddr2, 32'h0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_hresp", 32'(hresp), 32'd0);
      chk("rst_err_hready", 32'(err_hready), 32'd1);

      // Single write to slot 1; the data follows one cycle later.
      step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8400_0004, 32'h0);
      chk("wr_valid", 32'(cap_valid), 32'd1);
      chk("wr_sel", 32'(cap_sel), 32'b010);
      chk("wr_haddr1", haddr1, 32'h8400_0004);
      chk("wr_hwritereg", 32'(hwritereg), 32'd1);
      chk("wr_count1", 32'(wr_count), 32'd1);
      step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'hA5A5_0001);
      chk("wr_hwdata1", hwdata1, 32'hA5A5_0001);

      // Back-to-back SEQ reads in slot 2.
      step(1'b0, 1'b0, 1'b1, 2'b11, 32'h8800_0000, 32'h0);
      chk("rd0_valid", 32'(cap_valid), 32'd1);
      chk("rd0_sel", 32'(cap_sel), 32'b100);
      step(1'b0, 1'b0, 1'b1, 2'b11, 32'h8800_0004, 32'h0);
      chk("rd1_valid", 32'(cap_valid), 32'd1);
      chk("rd1_sel", 32'(cap_sel), 32'b100);
      chk("rd_count2", 32'(rd_count), 32'd2);
      chk("rd_haddr2", haddr2, 32'h8800_0000);

      // Qualifiers: a BUSY transfer, then a NONSEQ transfer with hreadyin low.
      step(1'b0, 1'b1, 1'b1, 2'b01, 32'h8000_0000, 32'h0);
      chk("busy_valid", 32'(cap_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 2'b10, 32'h8000_0000, 32'h0);
      chk("nrdy_valid", 32'(cap_valid), 32'd0);
      chk("qual_wr_count", 32'(wr_count), 32'd1);
      chk("qual_rd_count", 32'(rd_count), 32'd2);

      // Vector table: decode and qualification, including the window edges.
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h1111_0000, 1'b1, 3'b001};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h83FF_FFFC, 32'h0,         1'b1, 3'b001};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b11, 32'h8400_0000, 32'h2222_0000, 1'b1, 3'b010};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h87FF_FFFF, 32'h0,         1'b1, 3'b010};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h8BFF_FFFF, 32'h3333_0000, 1'b1, 3'b100};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'h0,         1'b0, 3'b000};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h8800_0000, 32'h0,         1'b0, 3'b100};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h8400_0000, 32'h0,         1'b0, 3'b010};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h8C00_FFFF, 32'h0,         1'b0, 3'b000};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,         1'b0, 3'b000};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,         1'b0, 3'b000};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0100, 32'h4444_0000, 1'b1, 3'b001};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0,         1'b0, 3'b000};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,         1'b0, 3'b000};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,         1'b0, 3'b000};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0,         1'b1, 3'b001};
      for (int i = 0; i < 16; i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].rdy, vecs[i].tr, vecs[i].addr, vecs[i].data);
         chk($sformatf("vec%0d_valid", i), 32'(cap_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_sel", i), 32'(cap_sel), 32'(vecs[i].exp_sel));
      end

      // Saturation: 17 mapped writes into a 4-bit counter.
      step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b1, 1'b1, 2'b10, BASE + 32'(i * 4), 32'(i));
      end
      chk("sat_wr_count", 32'(wr_count), 32'hF);
      chk("sat_rd_count", 32'(rd_count), 32'd0);

      // Unmapped NONSEQ access, followed by three idle cycles.
      step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0);
      chk("err_valid0", 32'(cap_valid), 32'd0);
      idle();
`ifdef AHB_SLV_ERR_RESP_EN
      chk("err1_hresp", 32'(cap_hresp), 32'd1);
      chk("err1_hready", 32'(cap_hready), 32'd0);
`else
      chk("err1_hresp", 32'(cap_hresp), 32'd0);
      chk("err1_hready", 32'(cap_hready), 32'd1);
`endif
      idle();
`ifdef AHB_SLV_ERR_RESP_EN
      chk("err2_hresp", 32'(cap_hresp), 32'd1);
`else
      chk("err2_hresp", 32'(cap_hresp), 32'd0);
`endif
      chk("err2_hready", 32'(cap_hready), 32'd1);
      idle();
      chk("err3_hresp", 32'(cap_hresp), 32'd0);
      chk("err3_hready", 32'(cap_hready), 32'd1);
      chk("err_wr_count", 32'(wr_count), 32'd0);
      chk("err_rd_count", 32'(rd_count), 32'd0);

      // Reset during a transfer drops it from the pipeline and the counters.
      step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0008, 32'h0);
      chk("mid_valid", 32'(cap_valid), 32'd1);
      step(1'b1, 1'b1, 1'b1, 2'b10, 32'h8000_0008, 32'hDEAD_BEEF);
      chk("mid_rst_valid", 32'(cap_valid), 32'd0);
      chk("mid_haddr1", haddr1, 32'h0);
      chk("mid_hwdata1", hwdata1, 32'h0);
      chk("mid_wr_count", 32'(wr_count), 32'd0);
      idle();
      chk("mid_haddr2", haddr2, 32'h0);
      chk("mid_hwritereg1", 32'(hwritereg1), 32'd0);

      // Random traffic checked against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0),
              1'($urandom),
              ($urandom_range(0, 4) != 0),
              2'($urandom),
              rand_addr(),
              $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB-to-APB bridge. It samples the AHB address/data phase and qualifies transfers into a single-cycle `valid`. It decodes the target peripheral select and provides 1- and 2-cycle delayed copies of address, write data and direction. These outputs feed the downstream APB controller FSM directly. It also keeps saturating read/write transfer counters and, optionally, generates the AHB ERROR response for unmapped addresses.

Parameters:
- CNT_W, 16, width of the read and write transfer counters.
- BASE_ADDR, 32'h8000_0000, start of the mapped window; three consecutive 64 MB slots.

Ports:
- hclk  in  1  bridge clock; all state updates on its rising edge.
- hreset  in  1  synchronous, active-high reset.
- hwrite  in  1  AHB direction; 1 = write.
- hreadyin  in  1  AHB HREADY as seen by this slave.
- htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- haddr  in  32  AHB address.
- hwdata  in  32  AHB write data; valid one cycle after its address phase.
- valid  out  1  qualified transfer this cycle (combinational).
- tempselx  out  3  one-hot peripheral select decoded from haddr (combinational).
- haddr1, haddr2  out  32  haddr delayed by 1 and 2 cycles.
- hwdata1, hwdata2  out  32  hwdata delayed by 1 and 2 cycles.
- hwritereg, hwritereg1  out  1  hwrite delayed by 1 and 2 cycles.
- wr_count, rd_count  out  CNT_W  accepted write / read transfer counts.
- hresp  out  2  AHB response; 00 OKAY, 01 ERROR.
- err_hready  out  1  this slave's HREADY contribution; 1 when not stalling.

Behaviour:

Synchronous, active-high reset; hreset is sampled on the rising edge of hclk. While hreset is high:
- All pipeline registers and both counters are cleared to 0.
- hresp = 00, err_hready = 1.
- valid = 0.

Pipeline:
- haddr1, hwdata1 and hwritereg load from haddr, hwdata and hwrite every clock.
- haddr2, hwdata2 and hwritereg1 load from the stage-1 registers every clock.
- The pipeline runs free; it is not gated by hreadyin.

Decode:
- in_range = haddr in [BASE_ADDR, BASE_ADDR + 32'h0BFF_FFFF].
- tempselx = 001 for slot 0 (+0x0000_0000..+0x03FF_FFFF).
- tempselx = 010 for slot 1 (+0x0400_0000..+0x07FF_FFFF).
- tempselx = 100 for slot 2 (+0x0800_0000..+0x0BFF_FFFF).
- tempselx = 000 for any out-of-range address.
- tempselx is purely combinational and is not gated by htrans.

Valid:
- active = hreadyin & htrans[1].
- valid = active & in_range & ~hreset & (err_state == ERR_IDLE).
- BUSY and IDLE transfers never assert valid.

Counters:
- On each clock with valid = 1, wr_count increments if hwrite = 1, otherwise rd_count increments.
- Both counters saturate at all-ones and never wrap.
- Only one counter can change per cycle.

Boundaries:
- Addresses BASE_ADDR + 32'h0BFF_FFFF and BASE_ADDR + 32'h0C00_FFFF fall on either side of the window edge: the first gives tempselx = 100 and valid, the second gives tempselx = 000 and no valid.
- BASE_ADDR - 1 gives tempselx = 000.
- Reset asserted mid-transfer clears all stages on the next edge. A transfer already in the pipeline is dropped; no partial state survives.

Optional Feature:

Macro: AHB_SLV_ERR_RESP_EN.

Defined: a 3-state error FSM ERR_IDLE → ERR_1 → ERR_2 → ERR_IDLE.
- ERR_IDLE → ERR_1 when active & ~in_range.
- ERR_1: hresp = 01, err_hready = 0.
- ERR_2: hresp = 01, err_hready = 1.
- ERR_2 always returns to ERR_IDLE after one cycle.
- valid is forced to 0 in ERR_1 and ERR_2.
- Unmapped accesses seen in ERR_1 or ERR_2 do not retrigger the FSM.
- An unmapped access in ERR_IDLE does not touch either counter.
- Reset returns the FSM to ERR_IDLE.

Undefined:
- No FSM is built.
- hresp is tied to 00 and err_hready to 1.
- err_state is treated as ERR_IDLE in the valid equation.
- Unmapped accesses are silently ignored (valid = 0).

Test Plan:
1. Reset: hold hreset = 1 for 2 cycles with haddr = 32'h8000_0010, htrans = 10 → valid = 0, haddr1 = haddr2 = 0, counts = 0, hresp = 00, err_hready = 1.
2. Single write: haddr = 32'h8400_0004, hwrite = 1, htrans = 10, hreadyin = 1, then hwdata = 32'hA5A5_0001 next cycle →
   - valid = 1 and tempselx = 010 in the address cycle.
   - Next cycle: haddr1 = 32'h8400_0004, hwritereg = 1, hwdata1 = 32'hA5A5_0001 one cycle after hwdata.
   - wr_count = 1.
3. Back-to-back SEQ reads at 32'h8800_0000 and 32'h8800_0004 →
   - valid = 1 in both cycles, tempselx = 100.
   - rd_count = 2.
   - haddr2 = 32'h8800_0000 two cycles after the first address.
4. Qualifiers: htrans = 01 (BUSY) at a mapped address → valid = 0. htrans = 10 with hreadyin = 0 → valid = 0. Neither counter changes in either case.
5. Saturation with CNT_W = 4: issue 17 mapped writes → wr_count stops at 4'hF; rd_count stays 0.
6. With AHB_SLV_ERR_RESP_EN: haddr = 32'h9000_0000, htrans = 10 →
   - Next cycle: hresp = 01, err_hready = 0.
   - Following cycle: hresp = 01, err_hready = 1.
   - Then hresp = 00.
   - valid = 0 throughout; counts unchanged.

   Without the macro, the same stimulus gives hresp = 00 and err_hready = 1 throughout.
